// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, forwarding select codes and the default wait limit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int unsigned WAIT_LIMIT_DEFAULT = 255;

  // EX/MEM has priority over MEM/WB; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(logic [4:0] src, logic [4:0] mem_rd,
                                         logic mem_reg_write, logic [4:0] wb_rd,
                                         logic wb_reg_write);
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src)) begin
      return FWD_EXMEM;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src)) begin
      return FWD_MEMWB;
    end else begin
      return FWD_REG;
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        dmem_ack;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        dmem_req;
  logic        mem_err;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
           ex_branch_taken, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, wb_rd,
           wb_reg_write, dmem_ack,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, fwd_a,
           fwd_b, dmem_req, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
           ex_branch_taken, mem_rd, mem_reg_write, mem_mem_read, mem_mem_write, wb_rd,
           wb_reg_write, dmem_ack,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, fwd_a,
           fwd_b, dmem_req, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Combinational operand forwarding selects for the EX stage.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b = fwd_sel(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze FSM, branch flush, load-use stall, forwarding.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       freeze, in_err, dmem_req, load_use;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    in_err     = 1'b0;
    dmem_req   = 1'b0;
    unique case (state_q)
      RUN: begin
        dmem_req = hz.mem_mem_read | hz.mem_mem_write;
        if (dmem_req && !hz.dmem_ack) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (hz.dmem_ack) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WaitLimit) begin
          freeze  = 1'b1;
          state_d = ERR;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR: begin
        in_err = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                     (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

  // A frozen pipeline holds any pending branch/load-use so it is acted on after release.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (freeze || in_err) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (hz.ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.idex_en    = idex_en;
  assign hz.exmem_en   = exmem_en;
  assign hz.memwb_en   = memwb_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign hz.dmem_req   = dmem_req;
  assign hz.mem_err    = in_err;

  pipe_fwd_unit u_fwd (
    .ex_rs         (hz.ex_rs),
    .ex_rt         (hz.ex_rt),
    .mem_rd        (hz.mem_rd),
    .mem_reg_write (hz.mem_reg_write),
    .wb_rd         (hz.wb_rd),
    .wb_reg_write  (hz.wb_reg_write),
    .fwd_a         (hz.fwd_a),
    .fwd_b         (hz.fwd_b)
  );

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      if (!pc_en && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (ifid_flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`else
  assign hz.stall_cycles = 32'd0;
  assign hz.flush_count  = 16'd0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, is the maximum number of MEM_WAIT cycles before the error state is entered; the legal range is 1..255.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads rs / rt.
REQ-006 ex_rs, ex_rt, ex_rd  in  5 each  register fields of the instruction in EX.
REQ-007 ex_mem_read  in  1  the EX instruction is a load.
REQ-008 ex_branch_taken  in  1  the EX instruction resolved as a taken branch or jump.
REQ-009 mem_rd, mem_reg_write, mem_mem_read, mem_mem_write  in  5/1/1/1  EX/MEM register outputs.
REQ-010 wb_rd, wb_reg_write  in  5/1  MEM/WB register outputs.
REQ-011 dmem_ack  in  1  data memory completes the current access this cycle.
REQ-012 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage-register load enables.
REQ-013 ifid_flush, idex_flush  out  1 each  load a bubble (all fields 0) into IF/ID and ID/EX.
REQ-014 fwd_a, fwd_b  out  2 each  EX operand select: 00 = regfile, 10 = EX/MEM alu_result, 01 = MEM/WB result.
REQ-015 dmem_req  out  1  data memory access request.
REQ-016 mem_err  out  1  sticky memory-timeout flag.
REQ-017 stall_cycles  out  32  performance counter; see Configuration.
REQ-018 flush_count  out  16  performance counter; see Configuration.

Function
REQ-019 The FSM SHALL have three states: RUN, MEM_WAIT and ERR; the state, an 8-bit wait counter and the performance counters are registered; all other outputs are combinational from the state and the inputs.
REQ-020 In RUN, dmem_req SHALL equal mem_mem_read | mem_mem_write.
REQ-021 In RUN, if dmem_req=1 and dmem_ack=0, the block SHALL drive all five enables and both flushes to 0 (freeze) and enter MEM_WAIT next cycle with the wait counter at 1.
REQ-022 In RUN, if dmem_req=1 and dmem_ack=1, there SHALL be no freeze (zero added latency).
REQ-023 In MEM_WAIT, dmem_req SHALL be 1. Without ack, the block SHALL freeze and increment the wait counter. With ack, the enables SHALL be released in that same cycle and the FSM SHALL return to RUN.
REQ-024 When the wait counter equals WAIT_LIMIT and dmem_ack=0, the FSM SHALL enter ERR; in ERR all enables, flushes and dmem_req are 0, mem_err is 1, and only reset exits ERR.
REQ-025 With no freeze, the priority SHALL be: branch flush, then load-use stall, then normal operation (all enables 1, flushes 0).
REQ-026 Branch flush: when ex_branch_taken=1, the block SHALL drive ifid_flush=1 and idex_flush=1 with pc_en=1.
REQ-027 Load-use stall: when ex_mem_read=1, ex_rd≠0, and ex_rd matches (id_uses_rs & id_rs) or (id_uses_rt & id_rt), the block SHALL drive pc_en=0, ifid_en=0 and idex_flush=1.
REQ-028 A branch or load-use condition that arrives during a freeze SHALL be held by the frozen stages and acted upon in the first unfrozen cycle.
REQ-029 fwd_a SHALL be 10 if mem_reg_write & mem_rd≠0 & mem_rd==ex_rs; otherwise 01 if wb_reg_write & wb_rd≠0 & wb_rd==ex_rs; otherwise 00. fwd_b SHALL follow the same rule with ex_rt. EX/MEM wins when both stages match.

Reset
REQ-030 Reset SHALL force the state to RUN, the wait counter to 0, mem_err to 0, and stall_cycles and flush_count to 0; the combinational outputs then follow the RUN rules.
REQ-031 Reset asserted during MEM_WAIT or ERR SHALL abandon the access: dmem_req drops in the same cycle once the inputs are idle.

Configuration
REQ-032 Macro PIPE_HAZARD_CTRL_PERF_EN SHALL control the performance counters.
REQ-033 With PIPE_HAZARD_CTRL_PERF_EN defined: stall_cycles counts every cycle with pc_en=0, and flush_count counts every cycle with ifid_flush=1; both counters saturate at their maximum value.
REQ-034 Without PIPE_HAZARD_CTRL_PERF_EN: both ports are present and tied to 0, and no counter flops are built.

Structure
REQ-035 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, MEM_WAIT, ERR), the fwd encodings (FWD_REG, FWD_EXMEM, FWD_MEMWB) and the default WAIT_LIMIT.
REQ-036 The forwarding logic SHALL be a separate combinational sub-module, pipe_fwd_unit, instantiated once.

Verification
REQ-037 Forwarding: ex_rs=5, mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1 -> fwd_a=10; repeat with mem_rd=0 -> fwd_a=01.
REQ-038 Load-use: ex_mem_read=1, ex_rd=3, id_rt=3, id_uses_rt=1 -> pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle; the same case with ex_rd=0 -> no stall.
REQ-039 Branch during load-use: ex_branch_taken=1 with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-040 Memory wait: mem_mem_read=1 with dmem_ack held low for 3 cycles, then high -> 3 frozen cycles, all enables 1 in the ack cycle, stall_cycles=3 (PERF_EN defined).
REQ-041 Timeout: WAIT_LIMIT=4 with dmem_ack never asserted -> ERR entered after 4 MEM_WAIT cycles, mem_err=1, dmem_req=0; asserting reset -> RUN and mem_err=0.
